mux_arb_2a1: RTL and testbench
==============================

MUX_ARB_2A1 -- requirements
Module: mux_arb_2a1

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width.
REQ-002 SHALL have parameter DEPTH, default 4, entries per input lane FIFO (power of two, >=2).
REQ-003 SHALL have parameter MAX_BURST, default 8, maximum consecutive words served from one lane.
REQ-004 SHALL have port clk2f  input  1  the single clock; all state updates occur on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port data_in_0  input  WIDTH  lane 0 data word.
REQ-007 SHALL have port valid_in_0  input  1  lane 0 word present this cycle.
REQ-008 SHALL have port data_in_1  input  WIDTH  lane 1 data word.
REQ-009 SHALL have port valid_in_1  input  1  lane 1 word present this cycle.
REQ-010 SHALL have port data_out_c  output  WIDTH  merged output word, registered.
REQ-011 SHALL have port valid_out_c  output  1  data_out_c valid, registered.
REQ-012 SHALL have ports full_0 and full_1  output  1 each  lane FIFO count == DEPTH, registered.
REQ-013 SHALL have ports overflow_0 and overflow_1  output  1 each  sticky dropped-word flag per lane.

Function
REQ-014 SHALL write data_in_x into lane-x FIFO at an edge where valid_in_x=1 and (count_x<DEPTH or lane x popped at the same edge).
REQ-015 SHALL drop the word and set overflow_x at an edge where valid_in_x=1, count_x==DEPTH and lane x is not popped; overflow_x stays 1 until reset.
REQ-016 SHALL keep per-lane FIFO order; read/write pointers wrap modulo DEPTH; count range 0..DEPTH.
REQ-017 SHALL implement arbiter states IDLE, SERVE_0, SERVE_1, WAIT_0 (last served lane 0), WAIT_1 (last served lane 1).
REQ-018 SHALL, in IDLE: pop lane 0 and go SERVE_0 if count_0>0; else pop lane 1 and go SERVE_1 if count_1>0; else stay.
REQ-019 SHALL, in SERVE_x with count_x>0 and burst counter <MAX_BURST: pop lane x, increment burst counter, stay.
REQ-020 SHALL, in SERVE_x with count_x==0 or burst counter ==MAX_BURST: pop nothing, go WAIT_x, clear burst counter.
REQ-021 SHALL, in WAIT_x: pop other lane y and go SERVE_y if count_y>0; else pop lane x and go SERVE_x if count_x>0; else stay.
REQ-022 SHALL count the pop made on entry to SERVE_x as burst word 1.
REQ-023 SHALL, on a pop, drive data_out_c=popped word and valid_out_c=1 after that edge; otherwise data_out_c=0 and valid_out_c=0.
REQ-024 SHALL present a word sampled at edge k on data_out_c no earlier than after edge k+1 (one-cycle minimum latency).
REQ-025 SHALL insert at least one valid_out_c=0 cycle between any two bursts, including same-lane bursts split by MAX_BURST.
REQ-026 SHALL evaluate pops using count values registered before the edge; a same-edge write is not poppable until the next edge.

Reset
REQ-027 SHALL, while reset=1, immediately force state=IDLE, all counts/pointers/burst counter=0, data_out_c=0, valid_out_c=0, full_0=full_1=0, overflow_0=overflow_1=0.
REQ-028 SHALL, on reset asserted mid-burst, discard all FIFO contents; no words accepted while reset=1.
REQ-029 SHALL resume normal operation at the first rising edge of clk2f after reset deasserts.

Verification
REQ-030 SHALL cover: lane 0 only, valid_in_0=1 for 3 cycles with 0x11,0x22,0x33 -> valid_out_c=1 with 0x11,0x22,0x33 starting one cycle after the first sampling edge, then valid_out_c=0.
REQ-031 SHALL cover: both lanes fed simultaneously, lane0 0xA0..0xA2, lane1 0xB0..0xB2 -> output 0xA0,0xA1,0xA2, one idle cycle, 0xB0,0xB1,0xB2.
REQ-032 SHALL cover: lane 0 fed continuously 0x00..0x0F with lane 1 holding 0xC0 -> 8 lane-0 words, idle cycle, 0xC0, idle cycle, lane 0 resumes at 0x08.
REQ-033 SHALL cover: lane 1 held in FIFO while lane 0 bursts 6 words with DEPTH=4 and lane 1 receiving 5 words -> full_1=1, fifth lane-1 word dropped, overflow_1=1 sticky, first 4 lane-1 words delivered in order.
REQ-034 SHALL cover: reset asserted asynchronously between clock edges mid-burst -> valid_out_c, data_out_c, full_x, overflow_x go 0 without a clock edge; no stale words output after release.
REQ-035 SHALL cover: after serving lane 1 (WAIT_1) with both lanes then receiving one word together -> lane 0 word output first, then idle cycle, then lane 1 word.

Source files
------------

// File: rtl/mux_arb_2a1.sv
// Two-lane FIFO merger: each lane buffers into a small FIFO, and a burst-limited
// arbiter drains the lanes onto one registered output, leaving an idle cycle between bursts.
module mux_arb_2a1 #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int MAX_BURST = 8
) (
  input  logic             clk2f,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in_0,
  input  logic             valid_in_0,
  input  logic [WIDTH-1:0] data_in_1,
  input  logic             valid_in_1,
  output logic [WIDTH-1:0] data_out_c,
  output logic             valid_out_c,
  output logic             full_0,
  output logic             full_1,
  output logic             overflow_0,
  output logic             overflow_1
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int BW = $clog2(MAX_BURST + 1);

  // state   | meaning
  // IDLE    | nothing served since reset
  // SERVE_0 | bursting lane 0
  // SERVE_1 | bursting lane 1
  // WAIT_0  | gap after a lane-0 burst, lane 1 preferred next
  // WAIT_1  | gap after a lane-1 burst, lane 0 preferred next
  typedef enum logic [2:0] {IDLE, SERVE_0, SERVE_1, WAIT_0, WAIT_1} state_t;

  state_t           state_q, state_d;
  logic [BW-1:0]    burst_q, burst_d;
  logic [WIDTH-1:0] mem_q    [2][DEPTH];
  logic [PW-1:0]    wr_ptr_q [2];
  logic [PW-1:0]    rd_ptr_q [2];
  logic [CW-1:0]    cnt_q    [2];
  logic [CW-1:0]    cnt_d    [2];
  logic [WIDTH-1:0] din      [2];
  logic [1:0]       vld_in, nonempty, pop, wr, ovf_set;

  assign din[0] = data_in_0;
  assign din[1] = data_in_1;
  assign vld_in = {valid_in_1, valid_in_0};

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      nonempty[i] = (cnt_q[i] != '0);
      // a full lane still accepts a word when it is popped at the same edge
      wr[i]       = vld_in[i] && ((cnt_q[i] != CW'(DEPTH)) || pop[i]);
      ovf_set[i]  = vld_in[i] && !wr[i];
      cnt_d[i]    = cnt_q[i] + CW'(wr[i]) - CW'(pop[i]);
    end
  end

  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    pop     = 2'b00;
    case (state_q)
      IDLE, WAIT_1: begin
        if (nonempty[0]) begin
          pop = 2'b01; state_d = SERVE_0; burst_d = BW'(1);
        end else if (nonempty[1]) begin
          pop = 2'b10; state_d = SERVE_1; burst_d = BW'(1);
        end
      end
      WAIT_0: begin
        if (nonempty[1]) begin
          pop = 2'b10; state_d = SERVE_1; burst_d = BW'(1);
        end else if (nonempty[0]) begin
          pop = 2'b01; state_d = SERVE_0; burst_d = BW'(1);
        end
      end
      SERVE_0: begin
        if (nonempty[0] && (burst_q < BW'(MAX_BURST))) begin
          pop = 2'b01; burst_d = burst_q + BW'(1);
        end else begin
          state_d = WAIT_0; burst_d = '0;
        end
      end
      SERVE_1: begin
        if (nonempty[1] && (burst_q < BW'(MAX_BURST))) begin
          pop = 2'b10; burst_d = burst_q + BW'(1);
        end else begin
          state_d = WAIT_1; burst_d = '0;
        end
      end
      default: begin
        state_d = IDLE; burst_d = '0;
      end
    endcase
  end

  // storage needs no reset: pointers and counts alone define what is readable
  always_ff @(posedge clk2f) begin
    for (int i = 0; i < 2; i++) begin
      if (wr[i] && !reset) mem_q[i][wr_ptr_q[i]] <= din[i];
    end
  end

  always_ff @(posedge clk2f or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      burst_q     <= '0;
      data_out_c  <= '0;
      valid_out_c <= 1'b0;
      full_0      <= 1'b0;
      full_1      <= 1'b0;
      overflow_0  <= 1'b0;
      overflow_1  <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
    end else begin
      state_q     <= state_d;
      burst_q     <= burst_d;
      valid_out_c <= |pop;
      data_out_c  <= pop[0] ? mem_q[0][rd_ptr_q[0]] :
                     pop[1] ? mem_q[1][rd_ptr_q[1]] : '0;
      full_0      <= (cnt_d[0] == CW'(DEPTH));
      full_1      <= (cnt_d[1] == CW'(DEPTH));
      overflow_0  <= overflow_0 | ovf_set[0];
      overflow_1  <= overflow_1 | ovf_set[1];
      for (int i = 0; i < 2; i++) begin
        if (wr[i])  wr_ptr_q[i] <= wr_ptr_q[i] + PW'(1);
        if (pop[i]) rd_ptr_q[i] <= rd_ptr_q[i] + PW'(1);
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

endmodule

// File: tb/tb_mux_arb_2a1.sv
// Bench for mux_arb_2a1: queue-based reference model compared every cycle,
// plus literal output sequences for each directed scenario.
module tb_mux_arb_2a1;
  localparam int WIDTH     = 8;
  localparam int DEPTH     = 4;
  localparam int MAX_BURST = 8;

  logic             clk2f = 1'b0;
  logic             reset = 1'b0;
  logic [WIDTH-1:0] data_in_0 = '0, data_in_1 = '0;
  logic             valid_in_0 = 1'b0, valid_in_1 = 1'b0;
  logic [WIDTH-1:0] data_out_c;
  logic             valid_out_c, full_0, full_1, overflow_0, overflow_1;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;
  int outlog[$];

  always #5 clk2f = ~clk2f;

  mux_arb_2a1 #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MAX_BURST(MAX_BURST)) dut (
    .clk2f(clk2f), .reset(reset),
    .data_in_0(data_in_0), .valid_in_0(valid_in_0),
    .data_in_1(data_in_1), .valid_in_1(valid_in_1),
    .data_out_c(data_out_c), .valid_out_c(valid_out_c),
    .full_0(full_0), .full_1(full_1),
    .overflow_0(overflow_0), .overflow_1(overflow_1)
  );

  // reference model: lane queues, the lane currently bursting (-1 = none) and the last lane served
  logic [WIDTH-1:0] mq0[$], mq1[$];
  int               cur = -1, last = -1, nburst = 0;
  bit               m_valid = 1'b0, m_ovf0 = 1'b0, m_ovf1 = 1'b0;
  logic [WIDTH-1:0] m_data = '0;

  function automatic int qsize(int l);
    return (l == 0) ? mq0.size() : mq1.size();
  endfunction

  task automatic model_step();
    int pop = -1;
    if (cur >= 0) begin
      if (qsize(cur) > 0 && nburst < MAX_BURST) begin
        pop = cur;
        nburst++;
      end else begin
        last = cur; cur = -1; nburst = 0;
      end
    end else begin
      int pref = (last == 0) ? 1 : 0;
      if (qsize(pref) > 0) pop = pref;
      else if (qsize(1 - pref) > 0) pop = 1 - pref;
      if (pop >= 0) begin cur = pop; nburst = 1; end
    end
    m_valid = (pop >= 0);
    m_data  = '0;
    if (pop == 0) m_data = mq0.pop_front();
    else if (pop == 1) m_data = mq1.pop_front();
    if (valid_in_0) begin
      if (mq0.size() < DEPTH) mq0.push_back(data_in_0); else m_ovf0 = 1'b1;
    end
    if (valid_in_1) begin
      if (mq1.size() < DEPTH) mq1.push_back(data_in_1); else m_ovf1 = 1'b1;
    end
  endtask

  always @(posedge clk2f or posedge reset) begin
    if (reset) begin
      mq0.delete(); mq1.delete();
      cur = -1; last = -1; nburst = 0;
      m_valid = 1'b0; m_data = '0; m_ovf0 = 1'b0; m_ovf1 = 1'b0;
    end else begin
      model_step();
    end
  end

  function automatic void chk(string nm, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
  endfunction

  always @(negedge clk2f) begin
    if (chk_en) begin
      chk("valid_out_c", int'(valid_out_c), int'(m_valid));
      chk("data_out_c",  int'(data_out_c),  int'(m_data));
      chk("full_0",      int'(full_0),      int'(mq0.size() == DEPTH));
      chk("full_1",      int'(full_1),      int'(mq1.size() == DEPTH));
      chk("overflow_0",  int'(overflow_0),  int'(m_ovf0));
      chk("overflow_1",  int'(overflow_1),  int'(m_ovf1));
      outlog.push_back(valid_out_c ? int'(data_out_c) : -1);
    end
  end

  task automatic chk_log(string nm, input int e[$]);
    for (int i = 0; i < e.size(); i++) begin
      int a = (i < outlog.size()) ? outlog[i] : -2;
      chk($sformatf("%s[%0d]", nm, i), a, e[i]);
    end
  endtask

  task automatic step();
    @(negedge clk2f);
    #1;
  endtask

  task automatic drive(bit v0, logic [WIDTH-1:0] d0, bit v1, logic [WIDTH-1:0] d1);
    valid_in_0 = v0; data_in_0 = d0;
    valid_in_1 = v1; data_in_1 = d1;
  endtask

  task automatic idle(int n);
    repeat (n) begin
      step();
      drive(1'b0, '0, 1'b0, '0);
    end
  endtask

  task automatic do_reset();
    step();
    reset = 1'b1;
    drive(1'b0, '0, 1'b0, '0);
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    int e[$];
    #1 reset = 1'b1;
    do_reset();
    chk("rst_valid", int'(valid_out_c), 0);
    chk("rst_full_0", int'(full_0), 0);
    chk_en = 1'b1;

    // single lane, three words
    for (int i = 0; i < 3; i++) begin
      step();
      if (i == 0) outlog.delete();
      drive(1'b1, 8'(8'h11 * (i + 1)), 1'b0, '0);
    end
    idle(6);
    e = '{-1, 'h11, 'h22, 'h33, -1, -1};
    chk_log("r030", e);

    // both lanes together: lane 0 first, gap, lane 1
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      if (i == 0) outlog.delete();
      drive(1'b1, 8'(8'hA0 + i), 1'b1, 8'(8'hB0 + i));
    end
    idle(8);
    e = '{-1, 'hA0, 'hA1, 'hA2, -1, 'hB0, 'hB1, 'hB2, -1};
    chk_log("r031", e);

    // burst limit: 8 lane-0 words, gap, lane-1 word, gap, lane 0 resumes
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step();
      if (i == 0) outlog.delete();
      drive(1'b1, 8'(i), (i == 0), 8'hC0);
    end
    idle(8);
    e.delete();
    e.push_back(-1);
    for (int i = 0; i < 8; i++) e.push_back(i);
    e.push_back(-1); e.push_back('hC0); e.push_back(-1);
    for (int i = 8; i < 16; i++) e.push_back(i);
    e.push_back(-1);
    chk_log("r032", e);

    // lane 1 fills while lane 0 bursts; fifth lane-1 word dropped
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step();
      if (i == 0) outlog.delete();
      if (i == 4) begin
        chk("r033_full_1", int'(full_1), 1);
        chk("r033_ovf_1_pre", int'(overflow_1), 0);
      end
      if (i == 5) chk("r033_ovf_1", int'(overflow_1), 1);
      drive(1'b1, 8'(8'hA0 + i), (i < 5), 8'(8'hB0 + i));
    end
    idle(10);
    e = '{-1, 'hA0, 'hA1, 'hA2, 'hA3, 'hA4, 'hA5, -1, 'hB0, 'hB1, 'hB2, 'hB3, -1};
    chk_log("r033", e);
    chk("r033_ovf_1_sticky", int'(overflow_1), 1);
    chk("r033_full_1_end", int'(full_1), 0);
    chk("r033_ovf_0", int'(overflow_0), 0);

    // asynchronous reset in the middle of a burst
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step();
      drive(1'b1, 8'(8'hA0 + i), (i < 5), 8'(8'hB0 + i));
    end
    #2;
    chk("r034_pre_valid", int'(valid_out_c), 1);
    chk("r034_pre_data", int'(data_out_c), 'hA3);
    chk("r034_pre_full_1", int'(full_1), 1);
    chk("r034_pre_ovf_1", int'(overflow_1), 1);
    reset = 1'b1;
    #1;
    chk("r034_valid", int'(valid_out_c), 0);
    chk("r034_data", int'(data_out_c), 0);
    chk("r034_full_1", int'(full_1), 0);
    chk("r034_ovf_1", int'(overflow_1), 0);
    drive(1'b1, 8'hEE, 1'b1, 8'hEE);
    step();
    step();
    step();
    drive(1'b0, '0, 1'b0, '0);
    reset = 1'b0;
    outlog.delete();
    idle(8);
    e = '{-1, -1, -1, -1, -1, -1, -1, -1};
    chk_log("r034_after", e);

    // from WAIT_1, simultaneous words: lane 0 wins
    do_reset();
    step();
    drive(1'b0, '0, 1'b1, 8'h5A);
    idle(3);
    step();
    outlog.delete();
    drive(1'b1, 8'h3C, 1'b1, 8'h7E);
    idle(6);
    e = '{-1, 'h3C, -1, 'h7E, -1};
    chk_log("r035", e);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
